cp0_except_commit: RTL

CP0_EXCEPT_COMMIT -- requirements
Module: cp0_except_commit

---
 rtl/cp0_except_commit.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/cp0_except_commit.sv
// CP0 register file with exception/ERET commit, MTC0 writes, Count/Compare timer and interrupt sampling.
// All updates land on the edge the request is presented; reads are combinational from the registers.
package cp0_pkg;
  typedef struct packed {
    logic        flush;
    logic [4:0]  code;
    logic        eret;
    logic [31:0] cur_pc;
    logic [31:0] jump_pc;
    logic [31:0] extra;
    logic        delayslot;
  } ExceptReq_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [2:0]  sel;
    logic [31:0] wdata;
  } CP0RegWriteReq_t;

  typedef struct packed {
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] prid;
    logic [31:0] cfg;
    logic [31:0] errorepc;
  } CP0Regs_t;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;
  localparam logic [4:0] CP0_CONFIG   = 5'd16;
  localparam logic [4:0] CP0_ERROREPC = 5'd30;

  localparam logic [31:0] CONFIG_VALUE = 32'h8000_0000;

  // Status: CU0, BEV, IM, KSU, ERL, EXL, IE are software-writable; Cause: only IP[1:0].
  function automatic logic [31:0] cp0_write_mask(input logic [4:0] addr, input logic [2:0] sel);
    logic [31:0] m;
    m = '0;
    if (sel == 3'd0) begin
      case (addr)
        CP0_COUNT, CP0_COMPARE, CP0_EPC, CP0_ERROREPC: m = 32'hFFFF_FFFF;
        CP0_STATUS: m = 32'h1040_FF1F;
        CP0_CAUSE:  m = 32'h0000_0300;
        default:    m = '0;
      endcase
    end
    return m;
  endfunction
endpackage

module cp0_except_commit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE   = 32'h0001_8000,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0004
) (
  input  logic            clk,
  input  logic            rst,
  input  ExceptReq_t      except_req,
  input  CP0RegWriteReq_t wb_cp0_reg_wr,
  input  logic [5:0]      int_hw,
  input  logic [4:0]      raddr,
  input  logic [2:0]      rsel,
  output logic [31:0]     rdata,
  output CP0Regs_t        cp0_regs,
  output logic            is_user_mode,
  output logic            timer_int
);
  logic [31:0] status_q, status_d, epc_q, epc_d, errorepc_q, errorepc_d;
  logic [31:0] badvaddr_q, badvaddr_d, count_q, count_d, compare_q, compare_d;
  logic        toggle_q, toggle_d, timer_q, timer_d, bd_q, bd_d;
  logic [1:0]  ce_q, ce_d, ip_sw_q, ip_sw_d;
  logic [4:0]  exccode_q, exccode_d, ip_hw_q, ip_hw_d;
  logic [31:0] wr_mask, wr_dat, cause;
  logic        unused_jump;

  assign unused_jump = ^except_req.jump_pc;

  assign wr_mask = cp0_write_mask(wb_cp0_reg_wr.waddr, wb_cp0_reg_wr.sel);
  assign wr_dat  = wb_cp0_reg_wr.wdata & wr_mask;

  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    errorepc_d = errorepc_q;
    badvaddr_d = badvaddr_q;
    compare_d  = compare_q;
    bd_d       = bd_q;
    ce_d       = ce_q;
    exccode_d  = exccode_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = int_hw[4:0];
    toggle_d   = ~toggle_q;
    count_d    = toggle_q ? count_q + 32'd1 : count_q;
    timer_d    = timer_q | ((count_q == compare_q) && (compare_q != '0));

    if (except_req.flush) begin
      if (!except_req.eret) begin
        // A nested exception keeps the EPC/BD of the original fault.
        if (!status_q[1]) begin
          epc_d = except_req.delayslot ? except_req.cur_pc - 32'd4 : except_req.cur_pc;
          bd_d  = except_req.delayslot;
        end
        status_d[1] = 1'b1;
        exccode_d   = except_req.code;
        ce_d        = (except_req.code == 5'd11) ? except_req.extra[1:0] : 2'b00;
        if (except_req.code >= 5'd1 && except_req.code <= 5'd5)
          badvaddr_d = except_req.extra;
      end else if (status_q[2]) begin
        status_d[2] = 1'b0;
      end else begin
        status_d[1] = 1'b0;
      end
    end else if (wb_cp0_reg_wr.we && wb_cp0_reg_wr.sel == 3'd0) begin
      case (wb_cp0_reg_wr.waddr)
        CP0_COUNT: begin
          count_d  = wr_dat;
          toggle_d = 1'b0;
        end
        CP0_COMPARE: begin
          compare_d = wr_dat;
          timer_d   = 1'b0;
        end
        CP0_STATUS:   status_d   = (status_q & ~wr_mask) | wr_dat;
        CP0_CAUSE:    ip_sw_d    = wr_dat[9:8];
        CP0_EPC:      epc_d      = wr_dat;
        CP0_ERROREPC: errorepc_d = wr_dat;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= STATUS_RESET;
      epc_q      <= '0;
      errorepc_q <= '0;
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      toggle_q   <= 1'b0;
      timer_q    <= 1'b0;
      bd_q       <= 1'b0;
      ce_q       <= '0;
      exccode_q  <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
    end else begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      errorepc_q <= errorepc_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      toggle_q   <= toggle_d;
      timer_q    <= timer_d;
      bd_q       <= bd_d;
      ce_q       <= ce_d;
      exccode_q  <= exccode_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
    end
  end

  // IP[7] follows the live int_hw[5] line; IP[6:2] is the sampled copy.
  assign cause = {bd_q, timer_q, ce_q, 12'b0, timer_q | int_hw[5], ip_hw_q, ip_sw_q,
                  1'b0, exccode_q, 2'b00};

  assign timer_int    = timer_q;
  assign is_user_mode = (status_q[4:3] == 2'b10) && !status_q[1] && !status_q[2];

  assign cp0_regs = '{badvaddr: badvaddr_q, count: count_q, compare: compare_q,
                      status: status_q, cause: cause, epc: epc_q, prid: PRID_VALUE,
                      cfg: CONFIG_VALUE, errorepc: errorepc_q};

  always_comb begin
    rdata = '0;
    if (rsel == 3'd0) begin
      case (raddr)
        CP0_BADVADDR: rdata = badvaddr_q;
        CP0_COUNT:    rdata = count_q;
        CP0_COMPARE:  rdata = compare_q;
        CP0_STATUS:   rdata = status_q;
        CP0_CAUSE:    rdata = cause;
        CP0_EPC:      rdata = epc_q;
        CP0_PRID:     rdata = PRID_VALUE;
        CP0_CONFIG:   rdata = CONFIG_VALUE;
        CP0_ERROREPC: rdata = errorepc_q;
        default:      rdata = '0;
      endcase
    end
  end
endmodule
